bsg_rr_scan_arb: RTL

BSG_RR_SCAN_ARB -- requirements
Module: bsg_rr_scan_arb

---
 rtl/bsg_rr_scan_arb_if.sv | 32 +++
 rtl/bsg_rr_scan_arb.sv | 102 ++++++++++
 2 files changed

// File: rtl/bsg_rr_scan_arb_if.sv
// Request/grant bundle for the round-robin scan arbiter.
// master = arbiter side, slave = requester/consumer side.
interface bsg_rr_scan_arb_if #(
  parameter int width_p = 4
);
  localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

  logic [width_p-1:0]      reqs_i;
  logic [width_p-1:0]      accept_o;
  logic                    v_o;
  logic [width_p-1:0]      grants_o;
  logic [tag_width_lp-1:0] tag_o;
  logic                    yumi_i;

  modport master (
    input  reqs_i,
    input  yumi_i,
    output accept_o,
    output v_o,
    output grants_o,
    output tag_o
  );

  modport slave (
    output reqs_i,
    output yumi_i,
    input  accept_o,
    input  v_o,
    input  grants_o,
    input  tag_o
  );
endinterface

// File: rtl/bsg_rr_scan_arb.sv
// Round-robin arbiter with a registered one-entry grant stage; the winner is
// found with an OR prefix scan over a pointer-masked request vector.
module bsg_rr_scan_arb #(
  parameter int width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_rr_scan_arb_if.master     arb
);
  localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

  if (width_p < 1 || width_p > 32) begin : g_bad_width
    $error("bsg_rr_scan_arb: width_p must be in 1..32");
  end

  logic [tag_width_lp-1:0]              last_r;
  logic                                 v_r;
  logic [width_p-1:0]                   grants_r;
  logic [tag_width_lp-1:0]              tag_r;

  logic [width_p-1:0]                   hi_mask;
  logic [width_p-1:0]                   masked;
  logic [width_p-1:0]                   cand;
  logic [width_p-1:0]                   scan;
  logic [width_p-1:0]                   winner;
  logic [tag_width_lp-1:0][width_p-1:0] tag_terms;
  logic [tag_width_lp-1:0]              win_tag;
  logic                                 load;
  logic                                 any_req;
  logic                                 capture;

  assign load    = ~v_r | arb.yumi_i;
  assign any_req = |arb.reqs_i;
  assign capture = reset_n_i & load & any_req;

  // Keep only requesters strictly after the pointer; fall back to the full
  // vector when none remain, which realises the wrap-around order.
  for (genvar gi = 0; gi < width_p; gi++) begin : g_mask
    localparam logic [tag_width_lp-1:0] idx_c = tag_width_lp'(gi);
    assign hi_mask[gi] = (idx_c > last_r);
  end

  assign masked = arb.reqs_i & hi_mask;
  assign cand   = (|masked) ? masked : arb.reqs_i;

  for (genvar gi = 0; gi < width_p; gi++) begin : g_scan
    if (gi == 0) begin : g_first
      assign scan[gi] = cand[gi];
    end else begin : g_rest
      assign scan[gi] = scan[gi-1] | cand[gi];
    end
  end

  assign winner = scan & ~(scan << 1);

  // One-hot to binary: each tag bit ORs the winner bits whose index has it set.
  for (genvar gi = 0; gi < width_p; gi++) begin : g_enc
    localparam logic [tag_width_lp-1:0] idx_c = tag_width_lp'(gi);
    for (genvar bi = 0; bi < tag_width_lp; bi++) begin : g_bit
      assign tag_terms[bi][gi] = winner[gi] & idx_c[bi];
    end
  end

  for (genvar bi = 0; bi < tag_width_lp; bi++) begin : g_tag
    assign win_tag[bi] = |tag_terms[bi];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_r      <= 1'b0;
      grants_r <= '0;
      tag_r    <= '0;
      last_r   <= tag_width_lp'(width_p - 1);
    end else if (load) begin
      if (any_req) begin
        v_r      <= 1'b1;
        grants_r <= winner;
        tag_r    <= win_tag;
        last_r   <= win_tag;
      end else begin
        v_r      <= 1'b0;
      end
    end
  end

  assign arb.accept_o = capture ? winner : '0;
  assign arb.v_o      = v_r;
  assign arb.grants_o = grants_r;
  assign arb.tag_o    = tag_r;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(arb.yumi_i && !v_r))
    else $error("bsg_rr_scan_arb: yumi_i asserted while v_o=0");

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      $onehot0(grants_r) && $onehot0(arb.accept_o))
    else $error("bsg_rr_scan_arb: grant or accept not one-hot");

  a_grant_matches_tag: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !v_r || (grants_r == (width_p'(1) << tag_r)))
    else $error("bsg_rr_scan_arb: grants_o does not match tag_o");
endmodule
